// File: rtl/arm_adder_pkg.sv
// Shared types and defaults for the shared-adder controller.
package arm_adder_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } adder_ctrl_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after rr_ptr, wrapping.
// Zero latency; grant is all-zero when enable is low or nothing requests.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  rr_ptr,
  input  logic             enable,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx
);

  logic [ID_W:0] w_pos;
  logic          w_found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_pos     = '0;
    w_found   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      // rr_ptr + k stays below 2*N_REQ, so one subtraction wraps it
      w_pos = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (w_pos >= (ID_W+1)'(N_REQ)) begin
        w_pos = w_pos - (ID_W+1)'(N_REQ);
      end
      if (enable && !w_found && req[w_pos[ID_W-1:0]]) begin
        grant[w_pos[ID_W-1:0]] = 1'b1;
        grant_idx              = w_pos[ID_W-1:0];
        w_found                = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_share_ctrl.sv
// Shares one external adder among N_REQ requesters with round-robin grant; transfer at T -> rsp_valid at T+2.
// One op in flight; while a response waits for rsp_ready no new request is granted.
module adder_share_ctrl
  import arm_adder_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]       add_a,
  output logic [WIDTH-1:0]       add_b,
  input  logic [WIDTH-1:0]       add_s,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_sum,
  input  logic                   rsp_ready
);

  adder_ctrl_state_t r_state;
  adder_ctrl_state_t w_state_nxt;

  logic [ID_W-1:0]  r_rr_ptr;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [ID_W-1:0]  r_op_id;
  logic             r_rsp_vld;
  logic [ID_W-1:0]  r_rsp_id;
  logic [WIDTH-1:0] r_rsp_sum;

  logic             w_arb_en;
  logic [N_REQ-1:0] w_grant;
  logic [ID_W-1:0]  w_gnt_idx;
  logic             w_xfer;
  logic [ID_W-1:0]  w_ptr_nxt;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;

  // Arbitration runs when idle, or when the pending result is consumed this cycle
  assign w_arb_en = (r_state == S_IDLE) || ((r_state == S_RESP) && rsp_ready);

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req       (req_valid),
    .rr_ptr    (r_rr_ptr),
    .enable    (w_arb_en),
    .grant     (w_grant),
    .grant_idx (w_gnt_idx)
  );

  assign w_xfer    = |(req_valid & w_grant);
  assign w_ptr_nxt = (w_gnt_idx == ID_W'(N_REQ-1)) ? '0 : w_gnt_idx + 1'b1;
  assign w_sel_a   = req_a[int'(w_gnt_idx)*WIDTH +: WIDTH];
  assign w_sel_b   = req_b[int'(w_gnt_idx)*WIDTH +: WIDTH];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_xfer) w_state_nxt = S_EXEC;
      S_EXEC: w_state_nxt = S_RESP;
      S_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = w_xfer ? S_EXEC : S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_rr_ptr  <= '0;
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_op_id   <= '0;
      r_rsp_vld <= 1'b0;
      r_rsp_id  <= '0;
      r_rsp_sum <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_xfer) begin
        r_op_a   <= w_sel_a;
        r_op_b   <= w_sel_b;
        r_op_id  <= w_gnt_idx;
        r_rr_ptr <= w_ptr_nxt;
      end
      // Adder output is only meaningful while the operand registers hold a fresh op
      if (r_state == S_EXEC) begin
        r_rsp_sum <= add_s;
        r_rsp_id  <= r_op_id;
        r_rsp_vld <= 1'b1;
      end else if ((r_state == S_RESP) && rsp_ready) begin
        r_rsp_vld <= 1'b0;
      end
    end
  end

  assign req_ready = w_grant;
  assign add_a     = r_op_a;
  assign add_b     = r_op_b;
  assign rsp_valid = r_rsp_vld;
  assign rsp_id    = r_rsp_id;
  assign rsp_sum   = r_rsp_sum;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Directed cycle-by-cycle vectors for adder_share_ctrl with an external adder and a sum scoreboard.
module tb_adder_share_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_valid;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [3:0]   req_ready;
  logic [31:0]  add_a;
  logic [31:0]  add_b;
  logic [31:0]  add_s;
  logic         rsp_valid;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_sum;
  logic         rsp_ready;

  always #5 clk = ~clk;

  adder_share_ctrl #(
    .N_REQ (4),
    .WIDTH (32),
    .ID_W  (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_s     (add_s),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_ready (rsp_ready)
  );

  // The shared adder lives outside the controller
  assign add_s = add_a + add_b;

  typedef struct packed {
    logic             rst;
    logic [3:0]       vld;
    logic             rrdy;
    logic [3:0][31:0] a;
    logic [3:0][31:0] b;
    logic [3:0]       e_rdy;
    logic             e_rv;
    logic [1:0]       e_id;
    logic [31:0]      e_sum;
  } vec_t;

  vec_t             vecs[$];
  logic [3:0][31:0] cur_a;
  logic [3:0][31:0] cur_b;
  logic [33:0]      sb[$];
  int               n_vec = 0;
  int               n_err = 0;

  function automatic void add_vec(input logic rst, input logic [3:0] vld, input logic rrdy,
                                  input logic [3:0] e_rdy, input logic e_rv,
                                  input logic [1:0] e_id, input logic [31:0] e_sum);
    vec_t v;
    v.rst = rst;  v.vld = vld;  v.rrdy = rrdy;
    v.a = cur_a;  v.b = cur_b;
    v.e_rdy = e_rdy;  v.e_rv = e_rv;  v.e_id = e_id;  v.e_sum = e_sum;
    vecs.push_back(v);
  endfunction

  function automatic void set_ops_a();
    for (int i = 0; i < 4; i++) begin
      cur_a[i] = 32'h10 + 32'(i);
      cur_b[i] = 32'h100 * 32'(i + 1);
    end
  endfunction

  task automatic apply_check(input int idx, input vec_t v);
    logic [33:0] exp_e;
    @(negedge clk);
    reset = v.rst;  req_valid = v.vld;  req_a = v.a;  req_b = v.b;  rsp_ready = v.rrdy;
    #1;
    n_vec++;
    if ({req_ready, rsp_valid, rsp_id, rsp_sum} !== {v.e_rdy, v.e_rv, v.e_id, v.e_sum}) begin
      n_err++;
      $display("FAIL vec%0d: rdy=%b rv=%b id=%0d sum=%h, expected rdy=%b rv=%b id=%0d sum=%h",
               idx, req_ready, rsp_valid, rsp_id, rsp_sum, v.e_rdy, v.e_rv, v.e_id, v.e_sum);
    end
    for (int i = 0; i < 4; i++) begin
      if (req_valid[i] && req_ready[i]) sb.push_back({2'(i), v.a[i] + v.b[i]});
    end
    if (rsp_valid && rsp_ready) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb vec%0d: unexpected rsp id=%0d sum=%h, expected none", idx, rsp_id, rsp_sum);
      end else begin
        exp_e = sb.pop_front();
        if ({rsp_id, rsp_sum} !== exp_e) begin
          n_err++;
          $display("FAIL sb vec%0d: rsp id=%0d sum=%h, expected id=%0d sum=%h",
                   idx, rsp_id, rsp_sum, exp_e[33:32], exp_e[31:0]);
        end
      end
    end
    if (v.rst) sb.delete();
  endtask

  initial begin
    int lat;
    reset = 1'b1;  req_valid = '0;  req_a = '0;  req_b = '0;  rsp_ready = 1'b0;
    repeat (2) @(negedge clk);

    set_ops_a();
    // Idle after reset
    for (int i = 0; i < 10; i++) add_vec(0, 4'b0000, 0, 4'b0000, 0, 0, 32'h0);
    // Single op from requester 0
    cur_a[0] = 32'h5;  cur_b[0] = 32'h7;
    add_vec(0, 4'b0001, 0, 4'b0001, 0, 0, 32'h0);
    add_vec(0, 4'b0000, 0, 4'b0000, 0, 0, 32'h0);
    add_vec(0, 4'b0000, 0, 4'b0000, 1, 0, 32'd12);
    add_vec(0, 4'b0000, 1, 4'b0000, 1, 0, 32'd12);
    add_vec(0, 4'b0000, 0, 4'b0000, 0, 0, 32'd12);
    // Overflow on requester 3, pointer wraps to 0
    cur_a[3] = 32'hFFFF_FFFF;  cur_b[3] = 32'h0000_0002;
    add_vec(0, 4'b1000, 0, 4'b1000, 0, 0, 32'd12);
    add_vec(0, 4'b0000, 0, 4'b0000, 0, 0, 32'd12);
    add_vec(0, 4'b0000, 1, 4'b0000, 1, 3, 32'h1);
    // Round robin, all requesting, consumer always ready
    set_ops_a();
    add_vec(0, 4'b1111, 1, 4'b0001, 0, 3, 32'h1);
    add_vec(0, 4'b1111, 1, 4'b0000, 0, 3, 32'h1);
    add_vec(0, 4'b1111, 1, 4'b0010, 1, 0, 32'h110);
    add_vec(0, 4'b1111, 1, 4'b0000, 0, 0, 32'h110);
    add_vec(0, 4'b1111, 1, 4'b0100, 1, 1, 32'h211);
    add_vec(0, 4'b1111, 1, 4'b0000, 0, 1, 32'h211);
    add_vec(0, 4'b1111, 1, 4'b1000, 1, 2, 32'h312);
    add_vec(0, 4'b1111, 1, 4'b0000, 0, 2, 32'h312);
    add_vec(0, 4'b1111, 1, 4'b0001, 1, 3, 32'h413);
    add_vec(0, 4'b1111, 1, 4'b0000, 0, 3, 32'h413);
    add_vec(0, 4'b1111, 1, 4'b0010, 1, 0, 32'h110);
    add_vec(0, 4'b1111, 1, 4'b0000, 0, 0, 32'h110);
    // Backpressure with requester 1 pending, then release
    cur_a[1] = 32'h8000_0000;  cur_b[1] = 32'h0000_0001;
    for (int i = 0; i < 5; i++) add_vec(0, 4'b0010, 0, 4'b0000, 1, 1, 32'h211);
    add_vec(0, 4'b0010, 1, 4'b0010, 1, 1, 32'h211);
    add_vec(0, 4'b0000, 1, 4'b0000, 0, 1, 32'h211);
    add_vec(0, 4'b0000, 1, 4'b0000, 1, 1, 32'h8000_0001);
    add_vec(0, 4'b0000, 0, 4'b0000, 0, 1, 32'h8000_0001);
    // Reset while requester 2's op is in EXEC
    cur_a[2] = 32'h0000_AAAA;  cur_b[2] = 32'h0000_5555;
    add_vec(0, 4'b0100, 0, 4'b0100, 0, 1, 32'h8000_0001);
    add_vec(1, 4'b0000, 0, 4'b0000, 0, 1, 32'h8000_0001);
    add_vec(0, 4'b0000, 1, 4'b0000, 0, 0, 32'h0);
    add_vec(0, 4'b0000, 1, 4'b0000, 0, 0, 32'h0);
    set_ops_a();
    add_vec(0, 4'b1111, 1, 4'b0001, 0, 0, 32'h0);
    add_vec(0, 4'b0000, 1, 4'b0000, 0, 0, 32'h0);
    add_vec(0, 4'b0000, 1, 4'b0000, 1, 0, 32'h110);
    add_vec(0, 4'b0000, 1, 4'b0000, 0, 0, 32'h110);

    for (int i = 0; i < vecs.size(); i++) apply_check(i, vecs[i]);

    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: %0d results outstanding, expected 0", sb.size());
    end

    // Latency measured with a bounded wait: transfer at T, rsp_valid at T+2
    @(negedge clk);
    req_a[2*32 +: 32] = 32'h3;  req_b[2*32 +: 32] = 32'h4;
    req_valid = 4'b0100;  rsp_ready = 1'b1;
    #1;
    n_vec++;
    if (req_ready !== 4'b0100) begin
      n_err++;
      $display("FAIL lat_grant: rdy=%b, expected 0100", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(negedge clk);
      #1;
      lat++;
    end
    n_vec++;
    if (lat != 2 || rsp_valid !== 1'b1 || rsp_sum !== 32'h7 || rsp_id !== 2'd2) begin
      n_err++;
      $display("FAIL lat_rsp: lat=%0d rv=%b id=%0d sum=%h, expected lat=2 rv=1 id=2 sum=00000007",
               lat, rsp_valid, rsp_id, rsp_sum);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
